// File: rtl/branch_commit_reporter.sv
// Collects resolved conditional branches from the commit slots into a circular
// outcome queue for the predictor, and reports mispredicts and running totals.
module branch_commit_reporter #(
  parameter int AMSB   = 51,
  parameter int CSLOTS = 4,
  parameter int QDEPTH = 16
) (
  input  logic              rst,
  input  logic              clk,
  input  logic              en,
  input  logic [CSLOTS-1:0] cmt_v,
  input  logic [CSLOTS-1:0] cmt_isbr,
  input  logic [CSLOTS-1:0] cmt_takb,
  input  logic [CSLOTS-1:0] cmt_pred,
  input  logic [AMSB:0]     cmt_ip [0:CSLOTS-1],
  output logic              cmt_stall,
  output logic              rpt_v,
  input  logic              rpt_rdy,
  output logic [AMSB:0]     rpt_ip,
  output logic              rpt_takb,
  output logic              misp_v,
  output logic [AMSB:0]     misp_ip,
  output logic [31:0]       br_cnt,
  output logic [31:0]       misp_cnt
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [AMSB+1:0] mem [0:QDEPTH-1];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;

  logic [CSLOTS-1:0] acc;
  logic [CSLOTS-1:0] misp;
  logic [CW-1:0]     n_acc;
  logic [CW-1:0]     n_misp;
  logic [PW-1:0]     wr_ptr [0:CSLOTS-1];
  logic              blocked;
  logic              misp_found;
  logic [AMSB:0]     misp_ip_next;
  logic              deq;
  logic [32:0]       br_sum;
  logic [32:0]       misp_sum;

  assign rpt_v     = (count != '0);
  assign cmt_stall = (count > CW'(QDEPTH - CSLOTS));
  assign rpt_ip    = mem[head][AMSB:0];
  assign rpt_takb  = mem[head][AMSB+1];
  assign deq       = rpt_v & rpt_rdy;
  assign br_sum    = {1'b0, br_cnt} + 33'(n_acc);
  assign misp_sum  = {1'b0, misp_cnt} + 33'(n_misp);

  // A taken branch in a lower slot squashes everything above it, whether or
  // not that lower slot was itself accepted.
  always_comb begin
    acc          = '0;
    misp         = '0;
    n_acc        = '0;
    n_misp       = '0;
    blocked      = 1'b0;
    misp_found   = 1'b0;
    misp_ip_next = '0;
    for (int n = 0; n < CSLOTS; n++) begin
      wr_ptr[n] = tail + n_acc[PW-1:0];
      if (en && !cmt_stall && cmt_v[n] && cmt_isbr[n] && !blocked) begin
        acc[n] = 1'b1;
        n_acc  = n_acc + CW'(1);
        if (cmt_pred[n] != cmt_takb[n]) begin
          misp[n] = 1'b1;
          n_misp  = n_misp + CW'(1);
          if (!misp_found) begin
            misp_found   = 1'b1;
            misp_ip_next = cmt_ip[n];
          end
        end
      end
      if (cmt_v[n] && cmt_isbr[n] && cmt_takb[n])
        blocked = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < CSLOTS; n++)
      if (acc[n])
        mem[wr_ptr[n]] <= {cmt_takb[n], cmt_ip[n]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      br_cnt   <= '0;
      misp_cnt <= '0;
      misp_v   <= 1'b0;
      misp_ip  <= '0;
    end else begin
      head   <= head + PW'(deq);
      tail   <= tail + n_acc[PW-1:0];
      count  <= count + n_acc - CW'(deq);
      br_cnt   <= br_sum[32]   ? 32'hFFFF_FFFF : br_sum[31:0];
      misp_cnt <= misp_sum[32] ? 32'hFFFF_FFFF : misp_sum[31:0];
      misp_v <= |misp;
      if (|misp)
        misp_ip <= misp_ip_next;
    end
  end

endmodule

// File: doc/branch_commit_reporter.md
BRANCH_COMMIT_REPORTER -- requirements
Module: branch_commit_reporter

Interface
REQ-001 SHALL have parameter AMSB, default 51, meaning MSB of instruction address.
REQ-002 SHALL have parameter CSLOTS, default 4, meaning commit slots per clock.
REQ-003 SHALL have parameter QDEPTH, default 16, meaning outcome queue entries (power of two, >= 2*CSLOTS).
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port en  input  1  enqueue enable; low blocks enqueue only.
REQ-007 SHALL have port cmt_v  input  CSLOTS  slot n commits this cycle.
REQ-008 SHALL have port cmt_isbr  input  CSLOTS  slot n is a conditional branch.
REQ-009 SHALL have port cmt_takb  input  CSLOTS  slot n resolved taken.
REQ-010 SHALL have port cmt_pred  input  CSLOTS  slot n was predicted taken.
REQ-011 SHALL have port cmt_ip  input  AMSB+1 x CSLOTS (array [0:CSLOTS-1])  slot n address.
REQ-012 SHALL have port cmt_stall  output  1  commit must hold; inputs ignored while high.
REQ-013 SHALL have port rpt_v  output  1  head outcome valid toward predictor.
REQ-014 SHALL have port rpt_rdy  input  1  predictor accepts head this cycle.
REQ-015 SHALL have port rpt_ip  output  AMSB+1  head branch address.
REQ-016 SHALL have port rpt_takb  output  1  head branch taken.
REQ-017 SHALL have port misp_v  output  1  one-cycle pulse, mispredict seen in previous cycle.
REQ-018 SHALL have port misp_ip  output  AMSB+1  address of lowest-slot mispredict of that cycle.
REQ-019 SHALL have ports br_cnt, misp_cnt  output  32 each  committed-branch and mispredict totals.

Function
REQ-020 Slot n SHALL be accepted iff en, !cmt_stall, cmt_v[n], cmt_isbr[n], and no slot j<n has cmt_v[j]&cmt_isbr[j]&cmt_takb[j].
REQ-021 Accepted slots SHALL be written to the queue in ascending slot order, compacted, {takb, ip} per entry, at the clock edge.
REQ-022 Queue SHALL be circular: head/tail pointers log2(QDEPTH) bits wrapping modulo QDEPTH; count log2(QDEPTH)+1 bits.
REQ-023 rpt_v SHALL equal (count != 0); rpt_ip/rpt_takb SHALL present the head entry combinationally from storage.
REQ-024 A dequeue SHALL occur iff rpt_v & rpt_rdy; head advances by 1.
REQ-025 Simultaneous enqueue/dequeue SHALL update count = count + n_accepted - deq in one cycle, no loss.
REQ-026 Latency: entry enqueued into empty queue at edge N SHALL show rpt_v=1 after edge N.
REQ-027 cmt_stall SHALL be combinational from registered count: high iff count > QDEPTH-CSLOTS; queue never overflows.
REQ-028 rpt_rdy with queue empty SHALL have no effect; head remains.
REQ-029 Mispredict for accepted slot SHALL be cmt_pred[n] != cmt_takb[n].
REQ-030 misp_v SHALL register high the edge after any accepted mispredict; misp_ip SHALL hold the lowest mispredicting slot address, unchanged when misp_v low.
REQ-031 br_cnt SHALL add number accepted, misp_cnt number of accepted mispredicts, per edge; each SHALL saturate at 32'hFFFFFFFF.
REQ-032 en low SHALL stop enqueue and counting; dequeue SHALL continue.

Reset
REQ-033 rst high SHALL immediately clear head, tail, count, br_cnt, misp_cnt, misp_v, misp_ip to 0; rpt_v=0, cmt_stall=0.
REQ-034 Reset mid-operation SHALL discard all queued entries; queue storage contents need not be cleared.

Verification
REQ-035 Slots 0..3 all branches, takb=0000, pred=0000 -> 4 entries in order ip0..ip3, br_cnt=4, misp_cnt=0, misp_v=0.
REQ-036 Slots all branches, takb=0010, pred=0000 -> only slots 0,1 enqueued; br_cnt=2; misp_cnt=1; misp_v=1 next cycle, misp_ip=ip1.
REQ-037 rpt_rdy=0, commit 4 branches/cycle -> after 4 cycles count=16, cmt_stall=1 from count 13; no entry lost; drain with rpt_rdy=1 yields 16 in order.
REQ-038 Queue holding 1 entry, 1 accepted and rpt_rdy=1 same cycle -> count stays 1, new entry at head next cycle.
REQ-039 Preload br_cnt near saturation (32'hFFFFFFFE), accept 4 -> br_cnt=32'hFFFFFFFF.
REQ-040 Assert rst with count=7 mid-stream -> rpt_v=0 without clock edge; post-reset, first enqueue emerges as first rpt.
